// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared state encoding and index-width helper for the
// round-robin FIFO arbiter.
package axis_arb_pkg;

    typedef enum logic {IDLE, STREAM} state_t;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin picker; returns the first
// requester at or after last_grant+1, wrapping modulo N.
module rr_priority_picker
    import axis_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int W = idw(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic         any,
    output logic [W-1:0] idx
);

    logic [N-1:0] rot;
    int           off;
    int           raw;

    // Doubling the request vector lets a plain right shift act as a rotate.
    always_comb begin
        rot = N'({req, req} >> (int'(last_grant) + 1));
        off = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        raw = int'(last_grant) + 1 + off;
        any = |req;
        idx = W'((raw >= N) ? raw - N : raw);
    end

endmodule

// File: rtl/axis_rr_fifo_arbiter.sv
// axis_rr_fifo_arbiter: drains NPORTS fall-through FIFOs onto one AXI-Stream
// master a whole packet at a time, with round-robin priority between packets.
module axis_rr_fifo_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NPORTS    = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BEATS = 64,
    parameter int CNTW      = 16,
    localparam int IDW      = idw(NPORTS)
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [NPORTS-1:0]        fifo_empty,
    input  logic [NPORTS*DWIDTH-1:0] fifo_data,
    input  logic [NPORTS-1:0]        fifo_last,
    output logic [NPORTS-1:0]        fifo_read,
    input  logic [NPORTS-1:0]        port_en,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [DWIDTH-1:0]        m_tdata,
    output logic                     m_tlast,
    output logic [IDW-1:0]           m_tid,
    output logic                     busy,
    output logic [CNTW-1:0]          pkt_count,
    output logic                     overlong,
    input  logic                     overlong_clr
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    state_t          state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [CNTW-1:0] pkt_count_q, pkt_count_d;
    logic            overlong_q, overlong_d;
    logic [IDW-1:0]  pick;
    logic            any;
    logic            hs;
    logic            set_ov;

    rr_priority_picker #(.N(NPORTS)) u_picker (
        .req        (~fifo_empty & port_en),
        .last_grant (last_grant_q),
        .any        (any),
        .idx        (pick)
    );

    always_comb begin
        m_tvalid     = (state_q == STREAM) && !fifo_empty[grant_q];
        m_tdata      = fifo_data[grant_q*DWIDTH +: DWIDTH];
        m_tlast      = fifo_last[grant_q];
        m_tid        = grant_q;
        hs           = m_tvalid && m_tready;
        fifo_read    = hs ? (NPORTS'(1) << grant_q) : '0;
        set_ov       = hs && !m_tlast && (beat_q == BW'(MAX_BEATS - 1));
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        pkt_count_d  = pkt_count_q;
        overlong_d   = set_ov || (overlong_q && !overlong_clr);
        if (state_q == IDLE) begin
            if (any) begin
                grant_d = pick;
                state_d = STREAM;
            end
        end else if (hs) begin
            if (m_tlast) begin
                last_grant_d = grant_q;
                pkt_count_d  = pkt_count_q + CNTW'(1);
                beat_d       = '0;
                state_d      = IDLE;
            end else begin
                // Saturate so one overlong packet flags once, not on every wrap.
                beat_d = beat_q + BW'(beat_q != BW'(MAX_BEATS));
            end
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(NPORTS - 1);
            beat_q       <= '0;
            pkt_count_q  <= '0;
            overlong_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            pkt_count_q  <= pkt_count_d;
            overlong_q   <= overlong_d;
        end
    end

    assign busy      = (state_q == STREAM);
    assign pkt_count = pkt_count_q;
    assign overlong  = overlong_q;

endmodule

// File: tb/tb_axis_rr_fifo_arbiter.sv
// tb_axis_rr_fifo_arbiter: cycle-by-cycle directed vectors with hand-computed
// outputs, plus sequences for starvation, overlong and mid-packet reset.
module tb_axis_rr_fifo_arbiter;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [3:0]  fifo_empty, fifo_last, port_en, fifo_read;
    logic [31:0] fifo_data;
    logic        m_tready, overlong_clr, m_tvalid, m_tlast, busy, overlong;
    logic [7:0]  m_tdata;
    logic [1:0]  m_tid;
    logic [2:0]  pkt_count;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    axis_rr_fifo_arbiter #(.NPORTS(4), .DWIDTH(8), .MAX_BEATS(4), .CNTW(3)) dut (
        .clk          (clk),
        .res          (res),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_last    (fifo_last),
        .fifo_read    (fifo_read),
        .port_en      (port_en),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .m_tid        (m_tid),
        .busy         (busy),
        .pkt_count    (pkt_count),
        .overlong     (overlong),
        .overlong_clr (overlong_clr)
    );

    typedef struct {
        logic [3:0]  emp, lst, en, erd;
        logic        rdy, clr, ev, eb, eov;
        logic [31:0] dat;
        logic [1:0]  eid;
        logic [7:0]  edat;
        logic [2:0]  epk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int emp, lst, en, rdy, clr, input logic [31:0] dat,
                                input int ev, erd, eid, edat, eb, epk, eov);
        vec_t v;
        v.emp = 4'(emp); v.lst = 4'(lst); v.en = 4'(en); v.rdy = 1'(rdy); v.clr = 1'(clr);
        v.dat = dat; v.ev = 1'(ev); v.erd = 4'(erd); v.eid = 2'(eid); v.edat = 8'(edat);
        v.eb = 1'(eb); v.epk = 3'(epk); v.eov = 1'(eov);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check outputs.
    task automatic step(input vec_t v, input string tag);
        @(negedge clk);
        fifo_empty = v.emp; fifo_last = v.lst; port_en = v.en;
        m_tready = v.rdy; overlong_clr = v.clr; fifo_data = v.dat;
        #1;
        chk({tag, ".tvalid"}, 32'(m_tvalid), 32'(v.ev));
        chk({tag, ".read"}, 32'(fifo_read), 32'(v.erd));
        chk({tag, ".busy"}, 32'(busy), 32'(v.eb));
        chk({tag, ".pkt"}, 32'(pkt_count), 32'(v.epk));
        chk({tag, ".ovl"}, 32'(overlong), 32'(v.eov));
        if (v.ev) begin
            chk({tag, ".tid"}, 32'(m_tid), 32'(v.eid));
            chk({tag, ".tdata"}, 32'(m_tdata), 32'(v.edat));
        end
    endtask

    localparam logic [31:0] D0 = 32'hC0804000;

    initial begin
        fifo_empty = 4'hF; fifo_last = 4'h0; port_en = 4'hF;
        fifo_data = 32'h0; m_tready = 1'b1; overlong_clr = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        // reset state
        tbl.push_back(mk('hF, 0, 'hF, 1, 0, D0, 0, 0, 0, 0, 0, 0, 0));
        // round robin over ports 0, 2, 3 with 3-beat packets
        tbl.push_back(mk('b0010, 0, 'hF, 1, 0, D0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk('b0010, 0, 'hF, 1, 0, 32'hC0804000, 1, 'b0001, 0, 'h00, 1, 0, 0));
        tbl.push_back(mk('b0010, 0, 'hF, 1, 0, 32'hC0804001, 1, 'b0001, 0, 'h01, 1, 0, 0));
        tbl.push_back(mk('b0010, 'b0001, 'hF, 1, 0, 32'hC0804002, 1, 'b0001, 0, 'h02, 1, 0, 0));
        tbl.push_back(mk('b0011, 0, 'hF, 1, 0, D0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk('b0011, 0, 'hF, 1, 0, 32'hC0804000, 1, 'b0100, 2, 'h80, 1, 1, 0));
        tbl.push_back(mk('b0011, 0, 'hF, 1, 0, 32'hC0814000, 1, 'b0100, 2, 'h81, 1, 1, 0));
        tbl.push_back(mk('b0011, 'b0100, 'hF, 1, 0, 32'hC0824000, 1, 'b0100, 2, 'h82, 1, 1, 0));
        tbl.push_back(mk('b0111, 0, 'hF, 1, 0, D0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(mk('b0111, 0, 'hF, 1, 0, 32'hC0804000, 1, 'b1000, 3, 'hC0, 1, 2, 0));
        tbl.push_back(mk('b0111, 0, 'hF, 1, 0, 32'hC1804000, 1, 'b1000, 3, 'hC1, 1, 2, 0));
        tbl.push_back(mk('b0111, 'b1000, 'hF, 1, 0, 32'hC2804000, 1, 'b1000, 3, 'hC2, 1, 2, 0));
        tbl.push_back(mk('hF, 0, 'hF, 1, 0, D0, 0, 0, 0, 0, 0, 3, 0));
        // backpressure on port 1, data A0..A3
        tbl.push_back(mk('b1101, 0, 'hF, 1, 0, 32'h0000A000, 0, 0, 0, 0, 0, 3, 0));
        tbl.push_back(mk('b1101, 0, 'hF, 1, 0, 32'h0000A000, 1, 'b0010, 1, 'hA0, 1, 3, 0));
        tbl.push_back(mk('b1101, 0, 'hF, 0, 0, 32'h0000A100, 1, 0, 1, 'hA1, 1, 3, 0));
        tbl.push_back(mk('b1101, 0, 'hF, 0, 0, 32'h0000A100, 1, 0, 1, 'hA1, 1, 3, 0));
        tbl.push_back(mk('b1101, 0, 'hF, 1, 0, 32'h0000A100, 1, 'b0010, 1, 'hA1, 1, 3, 0));
        tbl.push_back(mk('b1101, 0, 'hF, 0, 0, 32'h0000A200, 1, 0, 1, 'hA2, 1, 3, 0));
        tbl.push_back(mk('b1101, 0, 'hF, 1, 0, 32'h0000A200, 1, 'b0010, 1, 'hA2, 1, 3, 0));
        tbl.push_back(mk('b1101, 'b0010, 'hF, 1, 0, 32'h0000A300, 1, 'b0010, 1, 'hA3, 1, 3, 0));
        tbl.push_back(mk('hF, 0, 'hF, 1, 0, D0, 0, 0, 0, 0, 0, 4, 0));
        // enable mask 1010, single-beat packets, then port_en[1] dropped mid-packet; pkt_count wraps
        tbl.push_back(mk(0, 'hF, 'b1010, 1, 0, D0, 0, 0, 0, 0, 0, 4, 0));
        tbl.push_back(mk(0, 'hF, 'b1010, 1, 0, D0, 1, 'b1000, 3, 'hC0, 1, 4, 0));
        tbl.push_back(mk(0, 'hF, 'b1010, 1, 0, D0, 0, 0, 0, 0, 0, 5, 0));
        tbl.push_back(mk(0, 'hF, 'b1010, 1, 0, D0, 1, 'b0010, 1, 'h40, 1, 5, 0));
        tbl.push_back(mk(0, 'hF, 'b1010, 1, 0, D0, 0, 0, 0, 0, 0, 6, 0));
        tbl.push_back(mk(0, 'hF, 'b1010, 1, 0, D0, 1, 'b1000, 3, 'hC0, 1, 6, 0));
        tbl.push_back(mk(0, 'hF, 'b1010, 1, 0, D0, 0, 0, 0, 0, 0, 7, 0));
        tbl.push_back(mk(0, 'b1101, 'b1000, 1, 0, D0, 1, 'b0010, 1, 'h40, 1, 7, 0));
        tbl.push_back(mk(0, 'hF, 'b1000, 1, 0, 32'hC0804100, 1, 'b0010, 1, 'h41, 1, 7, 0));
        tbl.push_back(mk(0, 'hF, 'b1000, 1, 0, D0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 'hF, 'b1000, 1, 0, D0, 1, 'b1000, 3, 'hC0, 1, 0, 0));
        tbl.push_back(mk('hF, 0, 'hF, 1, 0, D0, 0, 0, 0, 0, 0, 1, 0));
        foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

        // port 2 runs dry for 3 cycles after beat 1
        step(mk('b1011, 0, 'hF, 1, 0, 32'h00900000, 0, 0, 0, 0, 0, 1, 0), "starve0");
        step(mk('b1011, 0, 'hF, 1, 0, 32'h00900000, 1, 'b0100, 2, 'h90, 1, 1, 0), "starve1");
        step(mk('b1011, 0, 'hF, 1, 0, 32'h00910000, 1, 'b0100, 2, 'h91, 1, 1, 0), "starve2");
        for (int i = 0; i < 3; i++)
            step(mk('hF, 0, 'hF, 1, 0, 32'h00920000, 0, 0, 0, 0, 1, 1, 0), $sformatf("starve_gap%0d", i));
        step(mk('b1011, 0, 'hF, 1, 0, 32'h00920000, 1, 'b0100, 2, 'h92, 1, 1, 0), "starve3");
        step(mk('b1011, 'b0100, 'hF, 1, 0, 32'h00930000, 1, 'b0100, 2, 'h93, 1, 1, 0), "starve4");
        step(mk('hF, 0, 'hF, 1, 0, D0, 0, 0, 0, 0, 0, 2, 0), "starve5");

        // 6-beat packet from port 0 against MAX_BEATS=4, then clear
        step(mk('b1110, 0, 'hF, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0), "ovl_arb");
        for (int i = 0; i < 6; i++)
            step(mk('b1110, (i == 5) ? 1 : 0, 'hF, 1, 0, 32'(i), 1, 'b0001, 0, i, 1, 2, (i >= 4) ? 1 : 0),
                 $sformatf("ovl_beat%0d", i));
        step(mk('hF, 0, 'hF, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1), "ovl_held");
        step(mk('hF, 0, 'hF, 1, 1, 0, 0, 0, 0, 0, 0, 3, 1), "ovl_clr");
        step(mk('hF, 0, 'hF, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0), "ovl_cleared");

        // set and clear in the same cycle: set wins
        step(mk('b1110, 0, 'hF, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0), "ovl2_arb");
        for (int i = 0; i < 4; i++)
            step(mk('b1110, 0, 'hF, 1, 1, 32'(i), 1, 'b0001, 0, i, 1, 3, 0), $sformatf("ovl2_beat%0d", i));
        step(mk('b1110, 1, 'hF, 1, 0, 32'h4, 1, 'b0001, 0, 4, 1, 3, 1), "ovl2_last");
        step(mk('hF, 0, 'hF, 1, 1, 0, 0, 0, 0, 0, 0, 4, 1), "ovl2_clr");
        step(mk('hF, 0, 'hF, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0), "ovl2_cleared");

        // reset while port 1 is on beat 2 of 5
        step(mk('b1101, 0, 'hF, 1, 0, 32'h00004000, 0, 0, 0, 0, 0, 4, 0), "rst_arb");
        step(mk('b1101, 0, 'hF, 1, 0, 32'h00004000, 1, 'b0010, 1, 'h40, 1, 4, 0), "rst_b0");
        step(mk('b1101, 0, 'hF, 1, 0, 32'h00004100, 1, 'b0010, 1, 'h41, 1, 4, 0), "rst_b1");
        step(mk('b1101, 0, 'hF, 1, 0, 32'h00004200, 1, 'b0010, 1, 'h42, 1, 4, 0), "rst_b2");
        #1 res = 1'b1;
        step(mk(0, 0, 'hF, 1, 0, 32'h00004300, 0, 0, 0, 0, 0, 0, 0), "rst_held");
        #1 res = 1'b0;
        step(mk(0, 'b0001, 'hF, 1, 0, 32'h00004300, 1, 'b0001, 0, 'h00, 1, 0, 0), "rst_port0");
        step(mk('hF, 0, 'hF, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), "rst_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
